// File: rtl/if_stage_if.sv
// Bundle between the fetch stage, the ID-stage control/hazard logic and the ROM.
// master: the fetch stage (drives PC, ROM address, IF/ID register, epc, irq_ack).
// slave : the surrounding pipeline/ROM (drives ROM data, hazards and redirects).
interface if_stage_if;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        exception;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] epc;
    logic        irq_ack;

    modport master (
        input  imem_data, stall, flush, branch_taken, branch_target,
               jump, jump_index, jr, jr_target, exception, irq,
        output imem_addr, pc, id_instr, id_pc, id_pc_plus4, id_valid, epc, irq_ack
    );

    modport slave (
        output imem_data, stall, flush, branch_taken, branch_target,
               jump, jump_index, jr, jr_target, exception, irq,
        input  imem_addr, pc, id_instr, id_pc, id_pc_plus4, id_valid, epc, irq_ack
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline
// register, supervisor-bit tracking (PC[31]) and epc capture for irq/exception.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - if_stage_if.master: ROM address/data, ID-stage redirects and
//           hazards, IF/ID register outputs, epc and irq_ack
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0008
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic            id_valid_q, id_valid_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            irq_ack_q, irq_ack_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jump_target;
    logic            redirect;
    logic            irq_take;

    // Sequential step keeps the supervisor bit and wraps the low 31 bits.
    assign pc_plus4    = {pc_q[31], pc_q[30:0] + 31'd4};
    assign jump_target = {id_pc_plus4_q[31:28], bus.jump_index, 2'b00};
    assign redirect    = bus.jr | bus.jump | bus.branch_taken;
    // Masked in supervisor mode; deferred (not lost) behind any ID redirect.
    assign irq_take    = bus.irq & ~pc_q[31] & ~bus.stall & ~bus.exception & ~redirect;

    // Next-state selection for PC, IF/ID, epc and irq_ack.
    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        epc_d         = epc_q;
        irq_ack_d     = 1'b0;

        if (bus.exception) begin
            // Exception overrides a stall on the same edge.
            pc_d          = EXC_VECTOR;
            epc_d         = id_pc_q;
            id_instr_d    = '0;
            id_valid_d    = 1'b0;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
        end else if (bus.stall) begin
            // PC and IF/ID freeze; a flush may still squash the held slot.
            if (bus.flush) begin
                id_instr_d = '0;
                id_valid_d = 1'b0;
            end
        end else begin
            id_instr_d    = bus.imem_data;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            id_valid_d    = 1'b1;

            if (bus.jr) begin
                pc_d = bus.jr_target;
            end else if (bus.jump) begin
                pc_d = jump_target;
            end else if (bus.branch_taken) begin
                pc_d = bus.branch_target;
            end else if (irq_take) begin
                // The instruction now in IF is squashed and re-fetched on return.
                pc_d      = IRQ_VECTOR;
                epc_d     = pc_q;
                irq_ack_d = 1'b1;
            end else begin
                pc_d = pc_plus4;
            end

            // No delay slot: every redirect squashes the wrong-path fetch.
            if (redirect || irq_take || bus.flush) begin
                id_instr_d = '0;
                id_valid_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_valid_q    <= 1'b0;
            epc_q         <= '0;
            irq_ack_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            epc_q         <= epc_d;
            irq_ack_q     <= irq_ack_d;
        end
    end

    assign bus.imem_addr   = pc_q[9:2];
    assign bus.pc          = pc_q;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.epc         = epc_q;
    assign bus.irq_ack     = irq_ack_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver applies one directed vector per cycle
// and queues the hand-computed state expected after that edge; a monitor pops
// and compares on the falling edge. ROM word = 32'h1234_5600 | address.
module tb_if_stage;

    logic clk;
    logic reset;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_data = 32'h1234_5600 | {24'h0, bus.imem_addr};

    typedef struct packed {
        logic        reset;
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] br_tgt;
        logic        jump;
        logic [25:0] jidx;
        logic        jr;
        logic [31:0] jr_tgt;
        logic        exc;
        logic        irq;
    } stim_t;

    typedef struct {
        int          tag;
        int          step;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] idpc;
        logic [31:0] idp4;
        logic        v;
        logic [31:0] epc;
        logic        ack;
    } exp_t;

    exp_t sb_q[$];
    int   cyc_cnt = 0;
    int   step_no = 0;
    int   checks  = 0;
    int   errors  = 0;
    bit   done    = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic exp_t ex(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] idpc, input logic [31:0] idp4,
                                input logic v, input logic [31:0] epc, input logic ack);
        exp_t e;
        e.tag = 0; e.step = 0;
        e.pc = pc; e.instr = instr; e.idpc = idpc; e.idp4 = idp4;
        e.v = v; e.epc = epc; e.ack = ack;
        return e;
    endfunction

    task automatic chk(input string name, input int stp, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", stp, name, act, exp);
        end
    endtask

    // Drive one vector for the next rising edge and queue its expected result.
    task automatic step(input stim_t s, input exp_t e);
        @(negedge clk);
        reset             = s.reset;
        bus.stall         = s.stall;
        bus.flush         = s.flush;
        bus.branch_taken  = s.br;
        bus.branch_target = s.br_tgt;
        bus.jump          = s.jump;
        bus.jump_index    = s.jidx;
        bus.jr            = s.jr;
        bus.jr_target     = s.jr_tgt;
        bus.exception     = s.exc;
        bus.irq           = s.irq;
        step_no++;
        e.tag  = cyc_cnt + 1;
        e.step = step_no;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the entry scheduled for this cycle; stale entries are errors.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].tag < cyc_cnt) begin
            checks++;
            errors++;
            $display("FAIL step %0d missed: expected at cycle %0d, now %0d",
                     sb_q[0].step, sb_q[0].tag, cyc_cnt);
            void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].tag == cyc_cnt) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("pc",          e.step, bus.pc,                      e.pc);
            chk("imem_addr",   e.step, {24'h0, bus.imem_addr},      {24'h0, e.pc[9:2]});
            chk("id_instr",    e.step, bus.id_instr,                e.instr);
            chk("id_pc",       e.step, bus.id_pc,                   e.idpc);
            chk("id_pc_plus4", e.step, bus.id_pc_plus4,             e.idp4);
            chk("id_valid",    e.step, {31'h0, bus.id_valid},       {31'h0, e.v});
            chk("epc",         e.step, bus.epc,                     e.epc);
            chk("irq_ack",     e.step, {31'h0, bus.irq_ack},        {31'h0, e.ack});
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_taken = 1'b0;
        bus.branch_target = '0; bus.jump = 1'b0; bus.jump_index = '0;
        bus.jr = 1'b0; bus.jr_target = '0; bus.exception = 1'b0; bus.irq = 1'b0;

        // Reset for two cycles, then fetch from 8000_0000 (ROM address 0).
        s = '0; s.reset = 1'b1;
        step(s, ex(32'h8000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        step(s, ex(32'h8000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h8000_0004, 32'h1234_5600, 32'h8000_0000, 32'h8000_0004, 1'b1, 32'h0, 1'b0));
        step(s, ex(32'h8000_0008, 32'h1234_5601, 32'h8000_0004, 32'h8000_0008, 1'b1, 32'h0, 1'b0));

        // Reach id_pc_plus4 = 8000_0044, then jal index 15, then jr to user space.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h8000_0040;
        step(s, ex(32'h8000_0040, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h8000_0044, 32'h1234_5610, 32'h8000_0040, 32'h8000_0044, 1'b1, 32'h0, 1'b0));
        s = '0; s.jump = 1'b1; s.jidx = 26'd15;
        step(s, ex(32'h8000_003C, 32'h0, 32'h8000_0044, 32'h8000_0048, 1'b0, 32'h0, 1'b0));
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h0000_0044;
        step(s, ex(32'h0000_0044, 32'h0, 32'h8000_003C, 32'h8000_0040, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h0000_0048, 32'h1234_5611, 32'h0000_0044, 32'h0000_0048, 1'b1, 32'h0, 1'b0));

        // Interrupt in user mode at 0000_0068; held irq then masked in supervisor.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h0000_0068;
        step(s, ex(32'h0000_0068, 32'h0, 32'h0000_0048, 32'h0000_004C, 1'b0, 32'h0, 1'b0));
        s = '0; s.irq = 1'b1;
        step(s, ex(32'h8000_0004, 32'h0, 32'h0000_0068, 32'h0000_006C, 1'b0, 32'h0000_0068, 1'b1));
        step(s, ex(32'h8000_0008, 32'h1234_5601, 32'h8000_0004, 32'h8000_0008, 1'b1, 32'h0000_0068, 1'b0));
        s = '0; s.irq = 1'b1; s.jr = 1'b1; s.jr_tgt = 32'h8000_0100;
        step(s, ex(32'h8000_0100, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0000_0068, 1'b0));
        s = '0; s.irq = 1'b1;
        step(s, ex(32'h8000_0104, 32'h1234_5640, 32'h8000_0100, 32'h8000_0104, 1'b1, 32'h0000_0068, 1'b0));

        // Interrupt collides with a taken branch: branch first, irq next cycle.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h0000_0080;
        step(s, ex(32'h0000_0080, 32'h0, 32'h8000_0104, 32'h8000_0108, 1'b0, 32'h0000_0068, 1'b0));
        s = '0; s.irq = 1'b1; s.br = 1'b1; s.br_tgt = 32'h0000_0084;
        step(s, ex(32'h0000_0084, 32'h0, 32'h0000_0080, 32'h0000_0084, 1'b0, 32'h0000_0068, 1'b0));
        s = '0; s.irq = 1'b1;
        step(s, ex(32'h8000_0004, 32'h0, 32'h0000_0084, 32'h0000_0088, 1'b0, 32'h0000_0084, 1'b1));
        s = '0;
        step(s, ex(32'h8000_0008, 32'h1234_5601, 32'h8000_0004, 32'h8000_0008, 1'b1, 32'h0000_0084, 1'b0));

        // Stall three cycles at 0000_0070 (irq/jump ignored), then resume.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h0000_0070;
        step(s, ex(32'h0000_0070, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0000_0084, 1'b0));
        s = '0; s.stall = 1'b1;
        step(s, ex(32'h0000_0070, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0000_0084, 1'b0));
        s.irq = 1'b1;
        step(s, ex(32'h0000_0070, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0000_0084, 1'b0));
        s.irq = 1'b0; s.jump = 1'b1; s.jidx = 26'h3;
        step(s, ex(32'h0000_0070, 32'h0, 32'h8000_0008, 32'h8000_000C, 1'b0, 32'h0000_0084, 1'b0));
        s = '0;
        step(s, ex(32'h0000_0074, 32'h1234_561C, 32'h0000_0070, 32'h0000_0074, 1'b1, 32'h0000_0084, 1'b0));

        // External flush, then flush under stall squashes a valid held slot.
        s = '0; s.flush = 1'b1;
        step(s, ex(32'h0000_0078, 32'h0, 32'h0000_0074, 32'h0000_0078, 1'b0, 32'h0000_0084, 1'b0));
        s = '0;
        step(s, ex(32'h0000_007C, 32'h1234_561E, 32'h0000_0078, 32'h0000_007C, 1'b1, 32'h0000_0084, 1'b0));
        s = '0; s.stall = 1'b1; s.flush = 1'b1;
        step(s, ex(32'h0000_007C, 32'h0, 32'h0000_0078, 32'h0000_007C, 1'b0, 32'h0000_0084, 1'b0));

        // Exception while stalled with id_pc = 0000_0050.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h0000_0050;
        step(s, ex(32'h0000_0050, 32'h0, 32'h0000_007C, 32'h0000_0080, 1'b0, 32'h0000_0084, 1'b0));
        s = '0;
        step(s, ex(32'h0000_0054, 32'h1234_5614, 32'h0000_0050, 32'h0000_0054, 1'b1, 32'h0000_0084, 1'b0));
        s = '0; s.exc = 1'b1; s.stall = 1'b1;
        step(s, ex(32'h8000_0008, 32'h0, 32'h0000_0054, 32'h0000_0058, 1'b0, 32'h0000_0050, 1'b0));
        s = '0;
        step(s, ex(32'h8000_000C, 32'h1234_5602, 32'h8000_0008, 32'h8000_000C, 1'b1, 32'h0000_0050, 1'b0));

        // Reset mid-operation discards a pending jr.
        s = '0; s.reset = 1'b1; s.jr = 1'b1; s.jr_tgt = 32'h0000_0200;
        step(s, ex(32'h8000_0000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h8000_0004, 32'h1234_5600, 32'h8000_0000, 32'h8000_0004, 1'b1, 32'h0, 1'b0));

        // Sequential wrap of bits [30:0] with bit 31 preserved.
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'h7FFF_FFFC;
        step(s, ex(32'h7FFF_FFFC, 32'h0, 32'h8000_0004, 32'h8000_0008, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h0000_0000, 32'h1234_56FF, 32'h7FFF_FFFC, 32'h0000_0000, 1'b1, 32'h0, 1'b0));
        s = '0; s.jr = 1'b1; s.jr_tgt = 32'hFFFF_FFFC;
        step(s, ex(32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0, 1'b0));
        s = '0;
        step(s, ex(32'h8000_0000, 32'h1234_56FF, 32'hFFFF_FFFC, 32'h8000_0000, 1'b1, 32'h0, 1'b0));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        done = 1'b1;
    end

    // Global time limit so the run always ends.
    initial begin
        fork
            wait (done);
            begin
                #20000;
                checks++;
                errors++;
                $display("FAIL timeout: done=0 expected done=1");
            end
        join_any
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
